// File: rtl/div_sqrt_prenorm_pipe_pkg.sv
// Shared types and encodings for the div/sqrt operand pre-normaliser.
package fpu_defs_div_sqrt_tp;

    typedef struct packed {
        logic snan;
        logic qnan;
        logic inf;
        logic subn;
        logic zero;
    } fp_class_t;

    localparam logic        C_OP_DIV  = 1'b0;
    localparam logic        C_OP_SQRT = 1'b1;
    localparam int unsigned C_RM_W    = 3;

endpackage

// File: rtl/div_sqrt_prenorm_pipe_lzc.sv
// Leading-zero counter with all-zero flag; count equals WIDTH when the input is zero.
module prenorm_lzc #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path can infer a latch.
        cnt_o   = CNT_W'(WIDTH);
        empty_o = 1'b1;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (empty_o && in_i[i]) begin
                cnt_o   = CNT_W'(int'(WIDTH) - 1 - i);
                empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/div_sqrt_prenorm_pipe.sv
// Elastic two-stage operand pre-normaliser feeding the iterative div/sqrt unit.
// Define PRENORM_FTZ_EN to flush subnormal inputs to signed zero.
module div_sqrt_prenorm_pipe
    import fpu_defs_div_sqrt_tp::*;
#(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23,
    parameter int unsigned RM_W   = C_RM_W
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RI,
    input  logic                      Valid_SI,
    output logic                      Ready_SO,
    input  logic                      Op_SI,
    input  logic [EXP_W+MANT_W:0]     Operand_a_DI,
    input  logic [EXP_W+MANT_W:0]     Operand_b_DI,
    input  logic [RM_W-1:0]           RM_SI,
    input  logic                      Kill_SI,
    output logic                      Valid_SO,
    input  logic                      Ready_SI,
    output logic signed [EXP_W+1:0]   Exp_a_DO,
    output logic signed [EXP_W+1:0]   Exp_b_DO,
    output logic [MANT_W:0]           Mant_a_DO,
    output logic [MANT_W:0]           Mant_b_DO,
    output logic                      Sign_z_DO,
    output logic [RM_W-1:0]           RM_DO,
    output logic                      Op_DO,
    output logic [4:0]                Class_a_DO,
    output logic [4:0]                Class_b_DO
);

    localparam int unsigned FP_W = 1 + EXP_W + MANT_W;
    localparam int unsigned MH_W = MANT_W + 1;
    localparam int unsigned LZ_W = $clog2(MH_W + 1);
    localparam int unsigned XE_W = EXP_W + 2;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MH_W-1:0]  mh;
        logic [LZ_W-1:0]  lz;
        fp_class_t        cls;
    } opnd_t;

    typedef struct packed {
        logic            op;
        logic [RM_W-1:0] rm;
        opnd_t           a;
        opnd_t           b;
    } stage1_t;

    typedef struct packed {
        logic [XE_W-1:0] exp;
        logic [MH_W-1:0] mant;
    } norm_t;

    typedef struct packed {
        norm_t           a;
        norm_t           b;
        fp_class_t       cls_a;
        fp_class_t       cls_b;
        logic            sign;
        logic [RM_W-1:0] rm;
        logic            op;
    } stage2_t;

    function automatic fp_class_t classify(input logic [EXP_W-1:0]  e,
                                           input logic [MANT_W-1:0] m,
                                           input logic              mh_zero);
        fp_class_t c;
        logic      e_ones;
        logic      is_nan;
        e_ones = &e;
        is_nan = e_ones & (m != '0);
        c.zero = mh_zero;
        c.subn = (e == '0) & ~mh_zero;
        c.inf  = e_ones & (m == '0);
        c.qnan = is_nan & m[MANT_W-1];
        c.snan = is_nan & ~m[MANT_W-1];
`ifdef PRENORM_FTZ_EN
        c.zero = mh_zero | (e == '0);
        c.subn = 1'b0;
`endif
        return c;
    endfunction

    // Subnormals use effective exponent 1 before the shift; specials pass through untouched.
    function automatic norm_t normalise(input opnd_t o);
        norm_t            n;
        logic [EXP_W-1:0] e_eff;
        e_eff  = (o.exp == '0) ? EXP_W'(1) : o.exp;
        n.mant = o.mh << o.lz;
        n.exp  = XE_W'(e_eff) - XE_W'(o.lz);
        if (o.cls.zero) begin
            n.mant = '0;
            n.exp  = '0;
        end else if (o.cls.inf | o.cls.qnan | o.cls.snan) begin
            n.mant = o.mh;
            n.exp  = XE_W'(o.exp);
        end
        return n;
    endfunction

    logic [EXP_W-1:0]  exp_a_raw, exp_b_raw;
    logic [MANT_W-1:0] man_a_raw, man_b_raw;
    logic [MH_W-1:0]   mh_a, mh_b;
    logic [LZ_W-1:0]   lz_a, lz_b;
    logic              mh_a_zero, mh_b_zero;

    assign exp_a_raw = Operand_a_DI[FP_W-2 -: EXP_W];
    assign exp_b_raw = Operand_b_DI[FP_W-2 -: EXP_W];
    assign man_a_raw = Operand_a_DI[MANT_W-1:0];
    assign man_b_raw = Operand_b_DI[MANT_W-1:0];
    assign mh_a      = {|exp_a_raw, man_a_raw};
    assign mh_b      = {|exp_b_raw, man_b_raw};

    prenorm_lzc #(.WIDTH(MH_W), .CNT_W(LZ_W)) i_lzc_a (
        .in_i    (mh_a),
        .cnt_o   (lz_a),
        .empty_o (mh_a_zero)
    );

    prenorm_lzc #(.WIDTH(MH_W), .CNT_W(LZ_W)) i_lzc_b (
        .in_i    (mh_b),
        .cnt_o   (lz_b),
        .empty_o (mh_b_zero)
    );

    logic    s1_v_q, s1_v_d;
    logic    s2_v_q, s2_v_d;
    stage1_t s1_q, s1_d;
    stage2_t s2_q, s2_d;
    logic    s2_adv;
    logic    s1_load;
    logic    s2_load;
    norm_t   norm_a, norm_b;

    assign s2_adv   = ~s2_v_q | Ready_SI;
    assign Ready_SO = ~s1_v_q | s2_adv;
    assign s1_load  = Valid_SI & Ready_SO;
    assign s2_load  = s1_v_q & s2_adv;

    always_comb begin
        s1_d.op     = Op_SI;
        s1_d.rm     = RM_SI;
        s1_d.a.sign = Operand_a_DI[FP_W-1];
        s1_d.a.exp  = exp_a_raw;
        s1_d.a.mh   = mh_a;
        s1_d.a.lz   = lz_a;
        s1_d.a.cls  = classify(exp_a_raw, man_a_raw, mh_a_zero);
        s1_d.b.sign = Operand_b_DI[FP_W-1];
        s1_d.b.exp  = exp_b_raw;
        s1_d.b.mh   = mh_b;
        s1_d.b.lz   = lz_b;
        s1_d.b.cls  = classify(exp_b_raw, man_b_raw, mh_b_zero);
    end

    always_comb begin
        norm_a     = normalise(s1_q.a);
        norm_b     = normalise(s1_q.b);
        s2_d.a     = norm_a;
        s2_d.b     = norm_b;
        s2_d.cls_a = s1_q.a.cls;
        s2_d.cls_b = s1_q.b.cls;
        s2_d.sign  = s1_q.a.sign ^ s1_q.b.sign;
        s2_d.rm    = s1_q.rm;
        s2_d.op    = s1_q.op;
        if (s1_q.op == C_OP_SQRT) begin
            s2_d.b     = '0;
            s2_d.cls_b = '0;
            s2_d.sign  = s1_q.a.sign;
        end
    end

    // A kill wins over everything, including an op accepted on the same edge.
    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        if (s2_adv) s2_v_d = s1_v_q;
        if (Ready_SO) s1_v_d = Valid_SI;
        if (Kill_SI) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end
    end

    // NOTE: all state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            // NOTE: data registers are reset too, so every output reads 0 right after reset.
            s1_q   <= '0;
            s2_q   <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            if (s1_load) s1_q <= s1_d;
            if (s2_load) s2_q <= s2_d;
        end
    end

    assign Valid_SO   = s2_v_q;
    assign Exp_a_DO   = s2_q.a.exp;
    assign Exp_b_DO   = s2_q.b.exp;
    assign Mant_a_DO  = s2_q.a.mant;
    assign Mant_b_DO  = s2_q.b.mant;
    assign Sign_z_DO  = s2_q.sign;
    assign RM_DO      = s2_q.rm;
    assign Op_DO      = s2_q.op;
    assign Class_a_DO = s2_q.cls_a;
    assign Class_b_DO = s2_q.cls_b;

endmodule

// File: tb/tb_div_sqrt_prenorm_pipe.sv
// Randomised self-checking bench for div_sqrt_prenorm_pipe (FP32 defaults).
module tb_div_sqrt_prenorm_pipe;

    logic              clk;
    logic              rst;
    logic              valid_i;
    logic              ready_o;
    logic              op_i;
    logic [31:0]       a_i;
    logic [31:0]       b_i;
    logic [2:0]        rm_i;
    logic              kill_i;
    logic              valid_o;
    logic              ready_i;
    logic signed [9:0] exp_a_o;
    logic signed [9:0] exp_b_o;
    logic [23:0]       mant_a_o;
    logic [23:0]       mant_b_o;
    logic              sign_z_o;
    logic [2:0]        rm_o;
    logic              op_o;
    logic [4:0]        class_a_o;
    logic [4:0]        class_b_o;

    div_sqrt_prenorm_pipe dut (
        .Clk_CI       (clk),
        .Rst_RI       (rst),
        .Valid_SI     (valid_i),
        .Ready_SO     (ready_o),
        .Op_SI        (op_i),
        .Operand_a_DI (a_i),
        .Operand_b_DI (b_i),
        .RM_SI        (rm_i),
        .Kill_SI      (kill_i),
        .Valid_SO     (valid_o),
        .Ready_SI     (ready_i),
        .Exp_a_DO     (exp_a_o),
        .Exp_b_DO     (exp_b_o),
        .Mant_a_DO    (mant_a_o),
        .Mant_b_DO    (mant_b_o),
        .Sign_z_DO    (sign_z_o),
        .RM_DO        (rm_o),
        .Op_DO        (op_o),
        .Class_a_DO   (class_a_o),
        .Class_b_DO   (class_b_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [9:0] ea;
        logic signed [9:0] eb;
        logic [23:0]       ma;
        logic [23:0]       mb;
        logic [4:0]        ca;
        logic [4:0]        cb;
        logic              sz;
        logic [2:0]        rm;
        logic              op;
        int                stage;
    } item_t;

    item_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_deliv = 0;
    bit    chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic IEEE unpacking: shift a subnormal up until the hidden bit appears.
    function automatic void ref_opnd(input logic [31:0] x, output logic signed [9:0] e_o,
                                     output logic [23:0] m_o, output logic [4:0] c_o);
        int          e;
        int          mh;
        int          ex;
        logic [22:0] m;
        bit          ftz;
        e   = int'(x[30:23]);
        m   = x[22:0];
        ftz = 1'b0;
`ifdef PRENORM_FTZ_EN
        ftz = 1'b1;
`endif
        if (e == 0 && (m == 0 || ftz)) begin
            c_o = 5'b00001; e_o = '0; m_o = '0;
        end else if (e == 255) begin
            m_o = {1'b1, m};
            e_o = 10'sd255;
            c_o = (m == 0) ? 5'b00100 : (m[22] ? 5'b01000 : 5'b10000);
        end else if (e == 0) begin
            mh = int'(m);
            ex = 1;
            while (mh < (1 << 23)) begin
                mh = mh * 2;
                ex = ex - 1;
            end
            m_o = mh[23:0];
            e_o = 10'(ex);
            c_o = 5'b00010;
        end else begin
            m_o = {1'b1, m};
            e_o = 10'(e);
            c_o = 5'b00000;
        end
    endfunction

    function automatic item_t ref_item(input logic op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [2:0] rm);
        item_t it;
        ref_opnd(a, it.ea, it.ma, it.ca);
        if (op) begin
            it.eb = '0; it.mb = '0; it.cb = '0;
            it.sz = a[31];
        end else begin
            ref_opnd(b, it.eb, it.mb, it.cb);
            it.sz = a[31] ^ b[31];
        end
        it.rm    = rm;
        it.op    = op;
        it.stage = 1;
        return it;
    endfunction

    // Pipeline occupancy model: up to two ops; the head reaches the output when stage 2 frees.
    always @(posedge clk) begin
        bit    acc;
        item_t it;
        acc = valid_i && ((q.size() < 2) || ready_i);
        if (rst || kill_i) begin
            q.delete();
        end else begin
            if (q.size() > 0 && q[0].stage == 2 && ready_i) void'(q.pop_front());
            if (q.size() > 0 && q[0].stage == 1) q[0].stage = 2;
            if (acc) begin
                it = ref_item(op_i, a_i, b_i, rm_i);
                q.push_back(it);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit ev;
            bit er;
            ev = (q.size() > 0) && (q[0].stage == 2);
            er = (q.size() < 2) || ready_i;
            check("ready_so", 32'(ready_o), 32'(er));
            check("valid_so", 32'(valid_o), 32'(ev));
            if (ev && valid_o) begin
                check("exp_a",   32'(exp_a_o),   32'(q[0].ea));
                check("exp_b",   32'(exp_b_o),   32'(q[0].eb));
                check("mant_a",  32'(mant_a_o),  32'(q[0].ma));
                check("mant_b",  32'(mant_b_o),  32'(q[0].mb));
                check("class_a", 32'(class_a_o), 32'(q[0].ca));
                check("class_b", 32'(class_b_o), 32'(q[0].cb));
                check("sign_z",  32'(sign_z_o),  32'(q[0].sz));
                check("rm",      32'(rm_o),      32'(q[0].rm));
                check("op",      32'(op_o),      32'(q[0].op));
            end
            if (valid_o && ready_i) n_deliv++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold one op on the input until an edge where the block was ready.
    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b);
        bit acc;
        acc     = 1'b0;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        rm_i    = 3'($urandom);
        valid_i = 1'b1;
        for (int n = 0; n < 32 && !acc; n++) begin
            @(negedge clk);
            acc = ready_o;
            tick();
        end
        valid_i = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: ready_so stayed 0 for 32 cycles");
        end
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 7))
            0:       begin e = 8'd0;   m = '0; end
            1, 2:    begin e = 8'd0;   m = 23'($urandom) >> $urandom_range(0, 22); end
            3:       begin e = 8'd255; m = '0; end
            4:       begin e = 8'd255; m = 23'($urandom); end
            default: begin e = 8'($urandom_range(1, 254)); m = 23'($urandom); end
        endcase
        return {1'($urandom), e, m};
    endfunction

    initial begin
        logic signed [9:0] pe;
        logic [23:0]       pm;
        logic [4:0]        pc;
        int                d0;

        rst = 1'b1; valid_i = 1'b0; op_i = 1'b0; a_i = '0; b_i = '0;
        rm_i = '0; kill_i = 1'b0; ready_i = 1'b1;
        repeat (2) tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Hand-computed anchors for the reference model.
        ref_opnd(32'h3F800000, pe, pm, pc);
        check("model_one_exp", 32'(pe), 32'd127);
        check("model_one_mant", 32'(pm), 32'h800000);
        ref_opnd(32'h7FA00000, pe, pm, pc);
        check("model_snan_cls", 32'(pc), 32'b10000);
        ref_opnd(32'h00000001, pe, pm, pc);
`ifdef PRENORM_FTZ_EN
        check("model_min_subn_exp", 32'(pe), 32'd0);
`else
        check("model_min_subn_exp", 32'(pe), 32'(-22));
`endif

        // Reset state.
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_exp_a", 32'(exp_a_o), 32'd0);
        check("rst_mant_a", 32'(mant_a_o), 32'd0);

        // 1.0 / 2.0 with two-cycle latency.
        send(1'b0, 32'h3F800000, 32'h40000000);
        check("lat_valid_early", 32'(valid_o), 32'd0);
        tick();
        check("lat_valid", 32'(valid_o), 32'd1);
        check("div1_exp_a", 32'(exp_a_o), 32'd127);
        check("div1_mant_a", 32'(mant_a_o), 32'h800000);
        check("div1_exp_b", 32'(exp_b_o), 32'd128);
        check("div1_sign", 32'(sign_z_o), 32'd0);

        // sqrt of the smallest subnormal.
        send(1'b1, 32'h00000001, 32'hC0490FDB);
        tick();
`ifdef PRENORM_FTZ_EN
        check("sqrt_cls_a", 32'(class_a_o), 32'b00001);
        check("sqrt_exp_a", 32'(exp_a_o), 32'd0);
        check("sqrt_mant_a", 32'(mant_a_o), 32'd0);
`else
        check("sqrt_cls_a", 32'(class_a_o), 32'b00010);
        check("sqrt_exp_a", 32'(exp_a_o), 32'(-22));
        check("sqrt_mant_a", 32'(mant_a_o), 32'h800000);
`endif
        check("sqrt_cls_b", 32'(class_b_o), 32'd0);
        check("sqrt_mant_b", 32'(mant_b_o), 32'd0);

        // -inf / sNaN, then -inf / qNaN.
        send(1'b0, 32'hFF800000, 32'h7FA00000);
        tick();
        check("inf_cls_a", 32'(class_a_o), 32'b00100);
        check("snan_cls_b", 32'(class_b_o), 32'b10000);
        check("inf_sign", 32'(sign_z_o), 32'd1);
        send(1'b0, 32'hFF800000, 32'h7FC00000);
        tick();
        check("qnan_cls_b", 32'(class_b_o), 32'b01000);
        repeat (2) tick();

        // Back-to-back stream with a three-cycle downstream stall.
        d0 = n_deliv;
        fork
            begin
                for (int i = 0; i < 4; i++) send(1'($urandom), rand_fp(), rand_fp());
            end
            begin
                ready_i = 1'b1;
                repeat (2) tick();
                ready_i = 1'b0;
                repeat (3) tick();
                ready_i = 1'b1;
            end
        join
        repeat (4) tick();
        check("b2b_delivered", 32'(n_deliv - d0), 32'd4);

        // Kill with two ops in flight and a third accepted on the same edge.
        ready_i = 1'b0;
        send(1'b0, rand_fp(), rand_fp());
        send(1'b0, rand_fp(), rand_fp());
        ready_i = 1'b1;
        valid_i = 1'b1;
        kill_i  = 1'b1;
        a_i     = rand_fp();
        tick();
        kill_i  = 1'b0;
        valid_i = 1'b0;
        d0      = n_deliv;
        for (int i = 0; i < 3; i++) begin
            check("kill_no_valid", 32'(valid_o), 32'd0);
            tick();
        end
        check("kill_no_delivery", 32'(n_deliv - d0), 32'd0);

        // Reset while stage 2 is stalled.
        ready_i = 1'b0;
        send(1'b0, 32'h40490FDB, 32'h3F800000);
        send(1'b1, 32'h00400000, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_valid", 32'(valid_o), 32'd0);
        check("rst2_ready", 32'(ready_o), 32'd1);
        check("rst2_exp_a", 32'(exp_a_o), 32'd0);
        check("rst2_mant_a", 32'(mant_a_o), 32'd0);
        check("rst2_class_a", 32'(class_a_o), 32'd0);
        tick();
        check("rst2_valid_later", 32'(valid_o), 32'd0);
        ready_i = 1'b1;

        // Random traffic with stalls, kills and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            kill_i  = ($urandom_range(0, 49) == 0);
            rst     = ($urandom_range(0, 255) == 0);
            op_i    = 1'($urandom);
            a_i     = rand_fp();
            b_i     = rand_fp();
            rm_i    = 3'($urandom);
            tick();
        end

        valid_i = 1'b0; ready_i = 1'b1; kill_i = 1'b0; rst = 1'b0;
        repeat (4) tick();
        check("drain_valid", 32'(valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
